// File: rtl/uart_sample_framer_pkg.sv
// uart_sample_framer_pkg: FSM encoding, sync byte default and frame length for the sample framer
package uart_sample_framer_pkg;
  typedef enum logic [1:0] {IDLE, SEND, WAIT_ACK, WAIT_DONE} state_t;
  localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'hA5;
  localparam int FRAME_LEN_PLAIN = 3;
  localparam int FRAME_LEN_CHK = 4;
`ifdef FRAMER_CHECKSUM_EN
  localparam int FRAME_LEN = FRAME_LEN_CHK;
`else
  localparam int FRAME_LEN = FRAME_LEN_PLAIN;
`endif
  localparam logic [1:0] LAST_IDX = 2'(FRAME_LEN - 1);
endpackage

// File: rtl/sample_fifo.sv
// sample_fifo: synchronous first-word-fall-through FIFO with wrap-bit pointers
module sample_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0] wr_ptr, rd_ptr;
  logic do_push, do_pop;
  assign do_pop = pop && !empty;
  // a pop in the same cycle frees the slot, so a push while full still lands
  assign do_push = push && (!full || do_pop);
  assign count = wr_ptr - rd_ptr;
  assign empty = count == '0;
  assign full = count == DEPTH[AW:0];
  assign dout = mem[rd_ptr[AW-1:0]];
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      wr_ptr <= do_push ? wr_ptr + 1'b1 : wr_ptr;
      rd_ptr <= do_pop ? rd_ptr + 1'b1 : rd_ptr;
    end
  end
endmodule

// File: rtl/uart_sample_framer.sv
// uart_sample_framer: buffers samples and streams them as SYNC/MSB/LSB[/CHK] frames (CHK with FRAMER_CHECKSUM_EN)
module uart_sample_framer
  import uart_sample_framer_pkg::*;
#(
  parameter int         DEPTH = 4,
  parameter logic [7:0] SYNC_BYTE = DEFAULT_SYNC_BYTE
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   sample_valid,
  input  logic [15:0]            sample,
  input  logic                   stream_en,
  input  logic                   tx_busy,
  output logic                   tx_start,
  output logic [7:0]             tx_data,
  output logic [$clog2(DEPTH):0] fifo_count,
  output logic                   overflow,
  output logic                   frame_active
);
  state_t state;
  logic [15:0] frame, head;
  logic [1:0] idx, nidx;
  logic [7:0] next_byte, chk;
  logic full, empty, pop;
  assign pop = state == IDLE && stream_en && !empty && !tx_busy;
  sample_fifo #(.WIDTH(16), .DEPTH(DEPTH)) u_fifo (
    .clk(clk), .reset(reset), .push(sample_valid), .pop(pop), .din(sample),
    .dout(head), .full(full), .empty(empty), .count(fifo_count)
  );
`ifdef FRAMER_CHECKSUM_EN
  assign chk = SYNC_BYTE ^ frame[15:8] ^ frame[7:0];
`else
  assign chk = '0;
`endif
  assign nidx = idx + 2'd1;
  assign next_byte = nidx == 2'd1 ? frame[15:8] : nidx == 2'd2 ? frame[7:0] : chk;
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      frame <= '0;
      idx <= '0;
      tx_start <= 1'b0;
      tx_data <= '0;
      overflow <= 1'b0;
      frame_active <= 1'b0;
    end else begin
      tx_start <= 1'b0;
      if (sample_valid && full && !pop) overflow <= 1'b1;
      case (state)
        IDLE: if (pop) begin
          frame <= head;
          idx <= '0;
          tx_data <= SYNC_BYTE;
          tx_start <= 1'b1;
          frame_active <= 1'b1;
          state <= SEND;
        end
        SEND: state <= WAIT_ACK;
        WAIT_ACK: if (tx_busy) state <= WAIT_DONE;
        WAIT_DONE: if (!tx_busy) begin
          if (idx == LAST_IDX) begin
            frame_active <= 1'b0;
            state <= IDLE;
          end else begin
            idx <= nidx;
            tx_data <= next_byte;
            tx_start <= 1'b1;
            state <= SEND;
          end
        end
      endcase
    end
  end
endmodule
